// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM.
// Holds state codes, MIPS opcode/funct values, ALU op codes and decode bundle.
package multicycle_ctrl_pkg;

    // FSM state codes, also exported on the debug state port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct field values
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    // ALU operation codes; 0 is kept as the idle/no-op value
    localparam logic [3:0] ALU_C_NOP = 4'd0;
    localparam logic [3:0] ALU_C_ADD = 4'd1;
    localparam logic [3:0] ALU_C_SUB = 4'd2;
    localparam logic [3:0] ALU_C_AND = 4'd3;
    localparam logic [3:0] ALU_C_OR  = 4'd4;
    localparam logic [3:0] ALU_C_XOR = 4'd5;
    localparam logic [3:0] ALU_C_SLL = 4'd6;
    localparam logic [3:0] ALU_C_SRL = 4'd7;
    localparam logic [3:0] ALU_C_SRA = 4'd8;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_ALU_R   = 3'd1,
        CL_SHIFT   = 3'd2,
        CL_ALU_I   = 3'd3,
        CL_LOAD    = 3'd4,
        CL_STORE   = 3'd5,
        CL_BRANCH  = 3'd6,
        CL_JUMP    = 3'd7
    } iclass_t;

    // Decoder output bundle
    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu_c;
        logic       sign_ext;
        logic       m2;
        logic       m3;
        logic       m4;
        logic       m6;
        logic       bne;
    } dec_t;

    // Classes that finish with a register-file write
    function automatic logic writes_rf(iclass_t c);
        return (c == CL_ALU_R) || (c == CL_SHIFT) ||
               (c == CL_ALU_I) || (c == CL_LOAD);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder for the multi-cycle controller.
// Ports: inst (instruction register) in; dec (class + datapath selects) out.
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_bits;

    assign op = inst[31:26];
    assign fn = inst[5:0];
    assign unused_bits = ^inst[25:6];

    always_comb begin
        dec = '0;
        dec.cls = CL_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                dec.m2 = 1'b1;
                dec.m3 = 1'b1;
                dec.cls = CL_ALU_R;
                case (fn)
                    FN_ADD: begin
                        dec.alu_c = ALU_C_ADD;
                        dec.sign_ext = 1'b1;
                    end
                    FN_ADDU: dec.alu_c = ALU_C_ADD;
                    FN_SUB: begin
                        dec.alu_c = ALU_C_SUB;
                        dec.sign_ext = 1'b1;
                    end
                    FN_SUBU: dec.alu_c = ALU_C_SUB;
                    FN_AND:  dec.alu_c = ALU_C_AND;
                    FN_OR:   dec.alu_c = ALU_C_OR;
                    FN_XOR:  dec.alu_c = ALU_C_XOR;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Shifts take the A operand from shamt
                        dec.cls = CL_SHIFT;
                        dec.m3 = 1'b0;
                        dec.alu_c = (fn == FN_SLL) ? ALU_C_SLL :
                                    (fn == FN_SRL) ? ALU_C_SRL :
                                                     ALU_C_SRA;
                    end
                    default: dec = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: begin
                dec.cls = CL_ALU_I;
                dec.m2 = 1'b1;
                dec.m3 = 1'b1;
                dec.m4 = 1'b1;
                dec.m6 = 1'b1;
                dec.sign_ext = (op == OP_ADDI);
                dec.alu_c = (op == OP_ANDI) ? ALU_C_AND :
                            (op == OP_ORI)  ? ALU_C_OR  :
                                              ALU_C_ADD;
            end
            OP_LW: begin
                dec.cls = CL_LOAD;
                dec.alu_c = ALU_C_ADD;
                dec.sign_ext = 1'b1;
                dec.m3 = 1'b1;
                dec.m4 = 1'b1;
                dec.m6 = 1'b1;
            end
            OP_SW: begin
                dec.cls = CL_STORE;
                dec.alu_c = ALU_C_ADD;
                dec.sign_ext = 1'b1;
                dec.m3 = 1'b1;
                dec.m4 = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.cls = CL_BRANCH;
                dec.alu_c = ALU_C_SUB;
                dec.sign_ext = 1'b1;
                dec.m3 = 1'b1;
                dec.bne = (op == OP_BNE);
            end
            OP_J: dec.cls = CL_JUMP;
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM sequencing PC/IM/RF/ALU/DM over several edges.
// Ports: inclk, rst, inst, zero, im_ready, dm_ready in; enables
// (PC_W IR_W IM_R DM_CS DM_R DM_W RF_W), selects (ALU_C SIGN_EXT M1..M6),
// debug state, illegal and bus_err pulses out.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 0,
    parameter int unsigned TO_W         = 8
) (
    input  logic        inclk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        im_ready,
    input  logic        dm_ready,
    output logic        PC_W,
    output logic        IR_W,
    output logic        IM_R,
    output logic        DM_CS,
    output logic        DM_R,
    output logic        DM_W,
    output logic        RF_W,
    output logic [3:0]  ALU_C,
    output logic        SIGN_EXT,
    output logic        M1,
    output logic        M5,
    output logic        M2,
    output logic        M3,
    output logic        M4,
    output logic        M6,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        bus_err
);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    dec_t            dec;
    logic            to_hit;
    logic            sel_en;

    logic pc_w, ir_w, im_r, dm_cs, dm_r, dm_w, rf_w;
    logic m1, m5, ill, berr;

    mc_decode u_dec (
        .inst (inst),
        .dec  (dec)
    );

    // Timeout fires only when the ready has still not arrived this cycle
    assign to_hit = (WAIT_TIMEOUT != 0) &&
                    (cnt_q == TO_W'(WAIT_TIMEOUT));

    always_ff @(posedge inclk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        pc_w    = 1'b0;
        ir_w    = 1'b0;
        im_r    = 1'b0;
        dm_cs   = 1'b0;
        dm_r    = 1'b0;
        dm_w    = 1'b0;
        rf_w    = 1'b0;
        m1      = 1'b0;
        m5      = 1'b0;
        ill     = 1'b0;
        berr    = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                im_r = 1'b1;
                if (im_ready) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = ST_DECODE;
                end else if (to_hit) begin
                    berr    = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec.cls == CL_ILLEGAL) begin
                    ill     = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                unique case (dec.cls)
                    CL_ALU_R, CL_SHIFT, CL_ALU_I: state_d = ST_WB;
                    CL_LOAD, CL_STORE:            state_d = ST_MEM;
                    CL_BRANCH: begin
                        m5   = dec.bne ? ~zero : zero;
                        pc_w = m5;
                    end
                    CL_JUMP: begin
                        m1   = 1'b1;
                        pc_w = 1'b1;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dm_ready) begin
                    dm_cs   = 1'b1;
                    dm_r    = (dec.cls == CL_LOAD);
                    dm_w    = (dec.cls == CL_STORE);
                    state_d = writes_rf(dec.cls) ? ST_WB : ST_FETCH;
                end else if (to_hit) begin
                    berr    = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    dm_cs = 1'b1;
                    dm_r  = (dec.cls == CL_LOAD);
                    dm_w  = (dec.cls == CL_STORE);
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_WB: begin
                rf_w    = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset cycle suppresses every write so an aborted instruction
    // leaves no partial architectural update behind
    assign PC_W    = pc_w & ~rst;
    assign IR_W    = ir_w & ~rst;
    assign RF_W    = rf_w & ~rst;
    assign DM_CS   = dm_cs & ~rst;
    assign DM_R    = dm_r & ~rst;
    assign DM_W    = dm_w & ~rst;
    assign illegal = ill & ~rst;
    assign bus_err = berr & ~rst;
    assign IM_R    = im_r;
    assign M1      = m1;
    assign M5      = m5;

    assign sel_en   = (state_q != ST_FETCH);
    assign ALU_C    = sel_en ? dec.alu_c : ALU_C_NOP;
    assign SIGN_EXT = sel_en & dec.sign_ext;
    assign M2       = sel_en & dec.m2;
    assign M3       = sel_en & dec.m3;
    assign M4       = sel_en & dec.m4;
    assign M6       = sel_en & dec.m6;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs are
// generated from instruction-level phase sequences and checked by a monitor.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int TO = 4;

    localparam int K_R   = 0;
    localparam int K_SH  = 1;
    localparam int K_I   = 2;
    localparam int K_LD  = 3;
    localparam int K_ST  = 4;
    localparam int K_BR  = 5;
    localparam int K_J   = 6;
    localparam int K_ILL = 7;

    // mnemonic indices: 0 add 1 addu 2 sub 3 subu 4 and 5 or 6 xor
    // 7 sll 8 srl 9 sra 10 addi 11 addiu 12 andi 13 ori 14 lw 15 sw
    // 16 beq 17 bne 18 j 19 illegal
    typedef struct packed {
        logic [2:0] st;
        logic pcw, irw, imr, dmcs, dmr, dmw, rfw;
        logic [3:0] aluc;
        logic sext, m1, m2, m3, m4, m5, m6, ill, berr;
    } obs_t;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        imr_in;
        logic        dmr_in;
        logic        z;
        obs_t        exp;
    } cyc_t;

    logic        inclk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0;
    logic        zero = 1'b0;
    logic        im_ready = 1'b0;
    logic        dm_ready = 1'b0;
    logic        PC_W, IR_W, IM_R, DM_CS, DM_R, DM_W, RF_W;
    logic [3:0]  ALU_C;
    logic        SIGN_EXT, M1, M5, M2, M3, M4, M6;
    logic [2:0]  state;
    logic        illegal, bus_err;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    obs_t e_m, g_m;

    multicycle_ctrl #(.WAIT_TIMEOUT(TO), .TO_W(8)) dut (
        .inclk(inclk), .rst(rst), .inst(inst), .zero(zero),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .PC_W(PC_W), .IR_W(IR_W), .IM_R(IM_R), .DM_CS(DM_CS),
        .DM_R(DM_R), .DM_W(DM_W), .RF_W(RF_W), .ALU_C(ALU_C),
        .SIGN_EXT(SIGN_EXT), .M1(M1), .M5(M5), .M2(M2), .M3(M3),
        .M4(M4), .M6(M6), .state(state), .illegal(illegal),
        .bus_err(bus_err)
    );

    always #5 inclk = ~inclk;

    function automatic string st_name(logic [2:0] s);
        case (s)
            3'd0: return "FETCH";
            3'd1: return "DECODE";
            3'd2: return "EXEC";
            3'd3: return "MEM";
            3'd4: return "WB";
            default: return "BAD";
        endcase
    endfunction

    always @(negedge inclk) begin
        if (exp_q.size() > 0) begin
            e_m = exp_q.pop_front();
            g_m = {state, PC_W, IR_W, IM_R, DM_CS, DM_R, DM_W, RF_W,
                   ALU_C, SIGN_EXT, M1, M2, M3, M4, M5, M6,
                   illegal, bus_err};
            vectors++;
            if (g_m !== e_m) begin
                miscompares++;
                $display("FAIL %s vec %0d: got %h want %h",
                         st_name(e_m.st), vectors, g_m, e_m);
            end
        end
    end

    function automatic int kind_of(int m);
        if (m <= 6) return K_R;
        if (m <= 9) return K_SH;
        if (m <= 13) return K_I;
        if (m == 14) return K_LD;
        if (m == 15) return K_ST;
        if (m <= 17) return K_BR;
        if (m == 18) return K_J;
        return K_ILL;
    endfunction

    function automatic logic [3:0] alu_of(int m);
        case (m)
            0, 1, 10, 11, 14, 15: return ALU_C_ADD;
            2, 3, 16, 17:         return ALU_C_SUB;
            4, 12:                return ALU_C_AND;
            5, 13:                return ALU_C_OR;
            6:                    return ALU_C_XOR;
            7:                    return ALU_C_SLL;
            8:                    return ALU_C_SRL;
            9:                    return ALU_C_SRA;
            default:              return ALU_C_NOP;
        endcase
    endfunction

    function automatic logic [31:0] enc(int m);
        logic [31:0] r;
        logic [5:0]  fn [10];
        logic [5:0]  op [9];
        fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
               6'h00, 6'h02, 6'h03};
        op = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04,
               6'h05, 6'h02};
        r = $urandom;
        if (m <= 9) begin
            r[31:26] = 6'h00;
            r[5:0] = fn[m];
        end else if (m <= 18) begin
            r[31:26] = op[m-10];
        end else begin
            case ($urandom_range(0, 2))
                0: r[31:26] = 6'h3F;
                1: begin
                    r[31:26] = 6'h00;
                    r[5:0] = 6'h08;
                end
                default: r[31:26] = 6'h0F;
            endcase
        end
        return r;
    endfunction

    function automatic obs_t sels(int m, logic [2:0] st);
        obs_t o;
        int   k;
        o = '0;
        k = kind_of(m);
        o.st = st;
        o.aluc = alu_of(m);
        o.sext = m inside {0, 2, 10, 14, 15, 16, 17};
        o.m2 = k inside {K_R, K_SH, K_I};
        o.m3 = k inside {K_R, K_I, K_LD, K_ST, K_BR};
        o.m4 = k inside {K_I, K_LD, K_ST};
        o.m6 = k inside {K_I, K_LD};
        return o;
    endfunction

    function automatic obs_t fetch_obs();
        obs_t o;
        o = '0;
        o.imr = 1'b1;
        return o;
    endfunction

    function automatic cyc_t fill(logic [31:0] ins);
        cyc_t c;
        c.rst = 1'b0;
        c.ins = ins;
        c.imr_in = 1'($urandom);
        c.dmr_in = 1'($urandom);
        c.z = 1'($urandom);
        c.exp = '0;
        return c;
    endfunction

    task automatic step(input cyc_t c);
        @(posedge inclk);
        #1;
        rst = c.rst;
        inst = c.ins;
        zero = c.z;
        im_ready = c.imr_in;
        dm_ready = c.dmr_in;
        exp_q.push_back(c.exp);
    endtask

    // One instruction: fw fetch waits, mw memory waits (mw<0: timeout),
    // rst_at = cycle index of an aborting reset (-1: none)
    task automatic run_instr(int m, logic [31:0] ins, int fw, int mw,
                             logic zb, int rst_at);
        cyc_t q[$];
        cyc_t c;
        int   k;
        int   n;
        k = kind_of(m);
        for (int i = 0; i < fw; i++) begin
            c = fill(ins);
            c.imr_in = 1'b0;
            c.exp = fetch_obs();
            q.push_back(c);
        end
        c = fill(ins);
        c.imr_in = 1'b1;
        c.exp = fetch_obs();
        c.exp.irw = 1'b1;
        c.exp.pcw = 1'b1;
        q.push_back(c);
        c = fill(ins);
        c.exp = sels(m, 3'd1);
        c.exp.ill = (k == K_ILL);
        q.push_back(c);
        if (k != K_ILL) begin
            c = fill(ins);
            c.exp = sels(m, 3'd2);
            if (k == K_BR) begin
                c.z = zb;
                c.exp.m5 = (m == 16) ? zb : !zb;
                c.exp.pcw = c.exp.m5;
            end
            if (k == K_J) begin
                c.exp.m1 = 1'b1;
                c.exp.pcw = 1'b1;
            end
            q.push_back(c);
        end
        if (k == K_LD || k == K_ST) begin
            n = (mw < 0) ? TO : mw;
            for (int i = 0; i < n; i++) begin
                c = fill(ins);
                c.dmr_in = 1'b0;
                c.exp = sels(m, 3'd3);
                c.exp.dmcs = 1'b1;
                c.exp.dmr = (k == K_LD);
                c.exp.dmw = (k == K_ST);
                q.push_back(c);
            end
            c = fill(ins);
            c.dmr_in = (mw >= 0);
            c.exp = sels(m, 3'd3);
            if (mw >= 0) begin
                c.exp.dmcs = 1'b1;
                c.exp.dmr = (k == K_LD);
                c.exp.dmw = (k == K_ST);
            end else begin
                c.exp.berr = 1'b1;
            end
            q.push_back(c);
        end
        if ((k inside {K_R, K_SH, K_I}) || (k == K_LD && mw >= 0)) begin
            c = fill(ins);
            c.exp = sels(m, 3'd4);
            c.exp.rfw = 1'b1;
            q.push_back(c);
        end
        if (rst_at >= 0 && rst_at < q.size()) begin
            q[rst_at].rst = 1'b1;
            q[rst_at].exp.pcw = 1'b0;
            q[rst_at].exp.irw = 1'b0;
            q[rst_at].exp.rfw = 1'b0;
            q[rst_at].exp.dmcs = 1'b0;
            q[rst_at].exp.dmr = 1'b0;
            q[rst_at].exp.dmw = 1'b0;
            q[rst_at].exp.ill = 1'b0;
            q[rst_at].exp.berr = 1'b0;
            while (q.size() > rst_at + 1) void'(q.pop_back());
        end
        foreach (q[i]) step(q[i]);
    endtask

    task automatic fetch_timeout();
        cyc_t c;
        for (int i = 0; i <= TO; i++) begin
            c = fill(32'h0);
            c.imr_in = 1'b0;
            c.exp = fetch_obs();
            c.exp.berr = (i == TO);
            step(c);
        end
    endtask

    initial begin
        cyc_t c;
        int   m;
        // reset held two cycles with im_ready high: no IR_W/PC_W allowed
        for (int i = 0; i < 2; i++) begin
            c = fill(32'h0);
            c.rst = 1'b1;
            c.imr_in = 1'b1;
            c.exp = fetch_obs();
            step(c);
        end
        run_instr(0, 32'h00221820, 0, 0, 1'b0, -1);
        run_instr(14, 32'h8C220004, 0, 3, 1'b0, -1);
        run_instr(16, 32'h10210003, 0, 0, 1'b1, -1);
        run_instr(16, 32'h10210003, 0, 0, 1'b0, -1);
        run_instr(17, 32'h14220003, 1, 0, 1'b0, -1);
        run_instr(17, 32'h14220003, 0, 0, 1'b1, -1);
        run_instr(18, 32'h08000010, 2, 0, 1'b0, -1);
        run_instr(19, 32'hFC000000, 0, 0, 1'b0, -1);
        fetch_timeout();
        run_instr(7, 32'h00021880, TO, 0, 1'b0, -1);
        run_instr(15, 32'hAC220004, 0, 3, 1'b0, 4);
        run_instr(5, 32'h00221825, 1, 0, 1'b0, -1);
        run_instr(14, 32'h8C220004, 0, -1, 1'b0, -1);
        run_instr(15, 32'hAC220008, 0, TO, 1'b0, -1);
        run_instr(14, 32'h8C220004, 0, 0, 1'b0, 4);
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 19) == 0) fetch_timeout();
            m = $urandom_range(0, 19);
            run_instr(m, enc(m), $urandom_range(0, TO),
                      ($urandom_range(0, 15) == 0) ? -1
                                                   : $urandom_range(0, TO),
                      1'($urandom),
                      ($urandom_range(0, 11) == 0) ? $urandom_range(0, 9)
                                                   : -1);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge inclk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
